// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared definitions for the bit-serial subtractor: controller
//               state encoding, legal WIDTH range and counter sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  // Controller state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Legal operand width range
  localparam int c_WIDTH_MIN = 1;
  localparam int c_WIDTH_MAX = 64;

  function automatic bit width_ok(input int w);
    return (w >= c_WIDTH_MIN) && (w <= c_WIDTH_MAX);
  endfunction

  // Bit counter width: max(1, clog2(w)); a 1- or 2-bit operand still needs a
  // one-bit counter.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_sub.sv
`default_nettype none
// ============================================================================
// Module      : full_sub
// Description : Combinational one-bit full subtractor cell, a - b - bin.
// Ports       : a, b, bin  - minuend bit, subtrahend bit, borrow in
//               d, bout    - difference bit, borrow out
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when a == b and a borrow is already pending
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit unsigned subtractor, d = a - b, LSB
//               first, one bit per clock through a single full_sub cell and a
//               borrow flip-flop. start/done handshake; one op per WIDTH+2
//               cycles.
// Ports       : clk, rst (async, active high)
//               start, a, b        - request and operands (sampled in IDLE)
//               busy, done         - RUN indicator, one-cycle completion pulse
//               d, bout, ovf       - difference, final borrow, signed overflow
// Config      : define SERIAL_SUB_OVF_EN to compute ovf; otherwise ovf = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int                 c_CNT_W = cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_bad
    $error("serial_subtractor: WIDTH must be in 1..64");
  end

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_borrow;
  logic [WIDTH-1:0]   r_d;
  logic               r_bout;
  logic               w_d;
  logic               w_bout;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_nxt;

  full_sub u_full_sub (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last = (r_state == RUN) && (r_cnt == c_LAST);

  // Result accumulator. Only WIDTH-1 bits are stored: the bit produced on the
  // final edge goes straight into d as its MSB together with the stored bits.
  if (WIDTH > 1) begin : g_res_wide
    logic [WIDTH-2:0] r_res;

    assign w_res_nxt = {w_d, r_res};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_res <= '0;
      end else if (r_state == IDLE && start) begin
        r_res <= '0;
      end else if (r_state == RUN) begin
        r_res <= w_res_nxt[WIDTH-1:1];
      end
    end
  end else begin : g_res_single
    assign w_res_nxt = w_d;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = start ? RUN : IDLE;
      RUN:     w_state_nxt = w_last ? DONE : RUN;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so no input reaches them
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Serial datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + c_CNT_W'(1);
          if (w_last) begin
            r_d    <= w_res_nxt;
            r_bout <= w_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign d    = r_d;
  assign bout = r_bout;

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are shifted out during RUN, so keep copies for the signed
  // overflow test on the final edge (w_d is then the result MSB).
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8 main
//               instance, WIDTH=1 corner instance) with a cycle-level
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

`ifdef SERIAL_SUB_OVF_EN
  localparam bit c_OVF_ON = 1'b1;
`else
  localparam bit c_OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bout, ovf;
  logic [W-1:0] d;

  logic         start1;
  logic [0:0]   a1, b1, d1;
  logic         busy1, done1, bout1, ovf1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An accepted op at edge k: busy after edges k..k+W-1, results and done
  // after edge k+W, next acceptance no earlier than edge k+W+2.
  int           cyc = 0;
  int           next_acc = 0;
  bit           pend = 0;
  int           pend_k = 0;
  logic [W-1:0] pend_d = '0;
  bit           pend_b = 0, pend_o = 0;
  logic [W-1:0] m_d = '0;
  bit           m_bout = 0, m_ovf = 0, m_busy = 0, m_done = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend = 0; m_d = '0; m_bout = 0; m_ovf = 0; m_busy = 0; m_done = 0;
      next_acc = 0;
    end else begin
      int sa, sb, sd;
      cyc++;
      m_done = 0;
      if (pend && cyc == pend_k + W) begin
        m_d = pend_d; m_bout = pend_b; m_ovf = pend_o; m_done = 1; pend = 0;
      end
      if (start && cyc >= next_acc) begin
        sa = a[W-1] ? int'(a) - 256 : int'(a);
        sb = b[W-1] ? int'(b) - 256 : int'(b);
        sd = sa - sb;
        pend_d = W'((int'(a) - int'(b)) & 255);
        pend_b = (a < b);
        pend_o = c_OVF_ON && (sd > 127 || sd < -128);
        pend = 1; pend_k = cyc; next_acc = cyc + W + 2;
      end
      m_busy = pend;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("d",    d,    m_d);
      check("bout", bout, m_bout);
      check("ovf",  ovf,  m_ovf);
    end
  end

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string tag);
    int nbusy = 0;
    bit seen = 0;
    @(negedge clk); start = 1; a = ia; b = ib;
    @(negedge clk); start = 0; a = W'($urandom); b = W'($urandom);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) nbusy++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_cycles"}, nbusy, W);
    check({tag, "_d"}, d, ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_model_d"}, m_d, ed);
  endtask

  initial begin
    int ndone;
    rst = 1; start = 0; a = '0; b = '0; start1 = 0; a1 = '0; b1 = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy1", busy1, 0);
    check("rst_d1", d1, 0);
    @(negedge clk); #2 rst = 0;
    chk_en = 1;
    repeat (2) @(negedge clk);

    run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, "op5a3c");
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, "op1020");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, c_OVF_ON, "op8001");

    // Start re-asserted during RUN must be dropped
    @(negedge clk); start = 1; a = 8'h05; b = 8'h03;
    @(negedge clk); a = 8'hFF; b = 8'h01;
    repeat (5) @(negedge clk);
    start = 0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_d", d, 8'h02);
    repeat (5) @(negedge clk);
    check("ignore_d_hold", d, 8'h02);

    // Asynchronous reset in the 4th RUN cycle
    @(negedge clk); start = 1; a = 8'h77; b = 8'h11;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", d, 0);
    check("abort_bout", bout, 0);
    @(negedge clk); #2 rst = 0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, "after_abort");

    // Back-to-back with start held high
    @(negedge clk); start = 1; a = 8'hFF; b = 8'h00;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("b2b_d", d, 8'hFF);
        check("b2b_bout", bout, 0);
      end
    end
    start = 0;
    check("b2b_done_count", ndone, 4);
    repeat (3) @(negedge clk);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom);
      b = W'($urandom);
      if (rst) begin
        #2 rst = 0;
      end else if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1;
      end
    end
    @(negedge clk); start = 0;
    if (rst) begin #2 rst = 0; end
    repeat (15) @(negedge clk);

    // WIDTH=1 instance: 0 - 1
    @(negedge clk); start1 = 1; a1 = 1'b0; b1 = 1'b1;
    @(negedge clk); start1 = 0;
    check("w1_busy", busy1, 1);
    check("w1_done_early", done1, 0);
    @(negedge clk);
    check("w1_done", done1, 1);
    check("w1_d", d1, 1);
    check("w1_bout", bout1, 1);
    check("w1_ovf", ovf1, c_OVF_ON);
    @(negedge clk);
    check("w1_done_gone", done1, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
